// File: rtl/crc_pkg.sv
// Shared constants and lane-placement helper for the CRC-32 datapath.
// Imported by the byte packer, its interface and the CRC stage.
package crc_pkg;

    localparam int          WORD_W         = 64;
    localparam int          BYTE_W         = 8;
    localparam int          BYTES_PER_WORD = 8;
    localparam logic [31:0] CRC_INIT       = 32'hFFFF_FFFF;

    // Bit offset of byte lane k; lane 0 is the first byte of a word.
    function automatic int lane_lo(input int k, input bit lsb_first);
        return lsb_first ? (k * BYTE_W) : (WORD_W - BYTE_W - k * BYTE_W);
    endfunction

endpackage

// File: rtl/crc_byte_packer_if.sv
// Byte-stream input and packed-word output of the CRC byte packer.
// The slave modport is the packer; master is the source/consumer side.
interface crc_byte_packer_if;
    import crc_pkg::*;

    logic [BYTE_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_last;
    logic [3:0]        word_bytes;
    logic              word_ready;
    logic              crc_align_valid;

    modport master (
        output in_data, in_valid, in_last, word_ready,
        input  in_ready, word_data, word_valid, word_last, word_bytes, crc_align_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, word_ready,
        output in_ready, word_data, word_valid, word_last, word_bytes, crc_align_valid
    );

endinterface

// File: rtl/crc_byte_packer.sv
// Packs a valid/ready byte stream into 64-bit words for the CRC stage and
// emits a strobe aligned with the CRC stage's registered output.
module crc_byte_packer
    import crc_pkg::*;
#(
    parameter bit         LSB_FIRST = 1'b1,
    parameter logic [7:0] PAD_BYTE  = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    crc_byte_packer_if.slave  bus
);

    localparam logic [WORD_W-1:0] PAD_FILL = {BYTES_PER_WORD{PAD_BYTE}};

    logic [WORD_W-1:0] acc_q, acc_d;
    logic [WORD_W-1:0] acc_merged;
    logic [2:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] word_data_q, word_data_d;
    logic              word_valid_q, word_valid_d;
    logic              word_last_q, word_last_d;
    logic [3:0]        word_bytes_q, word_bytes_d;
    logic              align_q, align_d;

    logic in_ready;
    logic accept;
    logic complete;
    logic handshake;

    // Combinational from word_ready so a draining slot never blocks a completing byte.
    assign in_ready  = !rst && (!word_valid_q || bus.word_ready);
    assign accept    = bus.in_valid && in_ready;
    assign complete  = accept && ((cnt_q == 3'd7) || bus.in_last);
    assign handshake = word_valid_q && bus.word_ready;

    // Assembly word with the incoming byte dropped into lane cnt_q.
    generate
        for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            localparam int LO = lane_lo(gi, LSB_FIRST);
            assign acc_merged[LO +: BYTE_W] =
                (cnt_q == 3'(gi)) ? bus.in_data : acc_q[LO +: BYTE_W];
        end
    endgenerate

    always_comb begin
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        word_data_d  = word_data_q;
        word_valid_d = word_valid_q;
        word_last_d  = word_last_q;
        word_bytes_d = word_bytes_q;
        align_d      = handshake;

        if (handshake) begin
            word_valid_d = 1'b0;
        end

        if (complete) begin
            acc_d        = PAD_FILL;
            cnt_d        = 3'd0;
            word_data_d  = acc_merged;
            word_valid_d = 1'b1;
            word_last_d  = bus.in_last;
            word_bytes_d = {1'b0, cnt_q} + 4'd1;
        end else if (accept) begin
            acc_d = acc_merged;
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q        <= PAD_FILL;
            cnt_q        <= 3'd0;
            word_data_q  <= '0;
            word_valid_q <= 1'b0;
            word_last_q  <= 1'b0;
            word_bytes_q <= 4'd0;
            align_q      <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            word_data_q  <= word_data_d;
            word_valid_q <= word_valid_d;
            word_last_q  <= word_last_d;
            word_bytes_q <= word_bytes_d;
            align_q      <= align_d;
        end
    end

    assign bus.in_ready        = in_ready;
    assign bus.word_data       = word_data_q;
    assign bus.word_valid      = word_valid_q;
    assign bus.word_last       = word_last_q;
    assign bus.word_bytes      = word_bytes_q;
    assign bus.crc_align_valid = align_q;

endmodule

// File: doc/crc_byte_packer.md
# crc_byte_packer

Upstream feeder for the 64-bit CRC-32 stage. It accepts a byte stream with valid/ready and an end-of-packet marker, and packs the bytes into 64-bit words. It presents each word to the CRC stage and holds it stable until handshaked. It also produces a one-cycle-delayed strobe aligned with the CRC stage's registered `crc_out`, so downstream logic knows which cycle's CRC belongs to which word.

## Interface
- `LSB_FIRST`, default 1: 1 places the first byte of a word in bits [7:0]; 0 places it in bits [63:56].
- `PAD_BYTE`, default 8'h00: fill value for unused byte lanes of a short final word.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_data`  in  8  byte from the upstream source.
- `in_valid`  in  1  `in_data` / `in_last` valid.
- `in_last`  in  1  byte is the final byte of a packet.
- `in_ready`  out  1  packer accepts a byte this cycle.
- `word_data`  out  64  packed word; drives the CRC stage's `data_in`.
- `word_valid`  out  1  `word_data` holds an unconsumed word.
- `word_last`  out  1  word contains the final byte of its packet.
- `word_bytes`  out  4  number of valid bytes in the word, 1..8.
- `word_ready`  in  1  consumer takes the word.
- `crc_align_valid`  out  1  high in the cycle in which the CRC stage's `crc_out` reflects the word handshaked in the previous cycle.

## Operation
- Internal state:
  - assembly register `acc[63:0]`, pre-filled with `PAD_BYTE` in every lane;
  - byte counter `cnt[2:0]`;
  - output register holding `word_data`, `word_valid`, `word_last`, `word_bytes`.
- Byte accept occurs when `in_valid && in_ready`. The byte is written to lane `cnt`. Lane `k` is bits [8k+7:8k] when `LSB_FIRST=1`, and bits [63-8k:56-8k] otherwise.
- Word completes when a byte is accepted with `cnt==7` or with `in_last==1`. On completion:
  - the word (including the current byte) is moved to the output register;
  - `word_bytes` is set to `cnt+1`;
  - `word_last` is set to `in_last`;
  - `acc` is refilled with `PAD_BYTE`;
  - `cnt` is set to 0.
- Otherwise `cnt` increments.
- `in_ready = !rst && (!word_valid || word_ready)`. This is a combinational path from `word_ready`, which is deliberate. In effect the assembly register only advances when the output slot is free or draining, so a completing byte is never blocked.
- Output handshake (`word_valid && word_ready`):
  - if a word completes in the same cycle, the output register reloads with the new word and `word_valid` stays 1;
  - otherwise `word_valid` clears.
- `word_data`, `word_last` and `word_bytes` stay stable while `word_valid && !word_ready`.
- When `word_valid=0`, `word_data` holds its last value and is not cleared.
- `crc_align_valid` is `(word_valid && word_ready)` registered by one cycle.
- Simultaneous `in_last` with `cnt==7`: a single word is produced with `word_bytes=8` and `word_last=1`.

## Timing
- Reset values:
  - `word_data` = 64'h0;
  - `word_valid`, `word_last`, `crc_align_valid` = 0;
  - `word_bytes` = 0;
  - `cnt` = 0;
  - `acc` = all lanes `PAD_BYTE`;
  - `in_ready` = 0 while `rst` is high and 1 on the first cycle after release.
- Latency: the completing byte is accepted at edge N; `word_valid` is high from edge N (visible in cycle N+1).
- Throughput: one byte per cycle sustained with `word_ready` tied high. The 64-bit word rate is one per 8 cycles.
- The CRC stage registers every cycle. `crc_out` corresponds to the handshaked word exactly when `crc_align_valid=1`, i.e. one cycle after the handshake.
- Reset mid-packet: partial word and pending output are discarded with no word emitted. The next accepted byte starts at lane 0.

## Structure
- Shared package `crc_pkg`:
  - constants: `WORD_W=64`, `BYTE_W=8`, `BYTES_PER_WORD=8`, `CRC_INIT=32'hFFFFFFFF`;
  - function `lane_lo(k, lsb_first)` returning the bit offset of byte lane k.
- No sub-module. The packer is one flat module of about 150 lines, instantiated beside the CRC stage in the top level.

## Test plan
- **Full word:** bytes 01..08, `in_last` on 08, `LSB_FIRST=1`, `word_ready=1` -> `word_data`=64'h0807060504030201, `word_bytes`=8, `word_last`=1, `crc_align_valid` high the cycle after.
- **Short word:** AA,BB,CC with `in_last` on CC -> `word_data`=64'h0000000000CCBBAA, `word_bytes`=3, `word_last`=1. With `PAD_BYTE`=8'hFF -> 64'hFFFFFFFFFFCCBBAA.
- **Byte order:** `LSB_FIRST=0`, bytes 01..08 -> `word_data`=64'h0102030405060708.
- **Back-pressure:** 16 bytes streamed continuously, `word_ready` low for 5 cycles after the first word appears -> `in_ready` low for exactly those 5 cycles, first word held stable, both words delivered in order, no byte lost or duplicated.
- **Reset mid-packet:** assert `rst` after 5 bytes, then send 11..18 -> all outputs return to reset values; first word after reset = 64'h1817161514131211.
- **Back-to-back turnover:** a 9-byte packet followed by a 1-byte packet with `word_ready=1` -> words with `word_bytes` 8 (`word_last`=0), 1 (`word_last`=1), 1 (`word_last`=1), with no bubble cycle on `in_ready`.
